// File: rtl/bus_trace_buffer.sv
// Bus-cycle trace capture for the AK6502 CPU bus: classifies ph2-qualified cycles,
// filters by mode and stores them in a linear or circular (pre-trigger) trace memory.
module bus_trace_buffer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ph2,
    input  logic                       sync,
    input  logic                       rw,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [DATA_W-1:0]          data_o,
    input  logic [1:0]                 mode,
    input  logic                       trig_en,
    input  logic [ADDR_W-1:0]          trig_addr,
    input  logic [DEPTH_LOG2:0]        post_count,
    input  logic                       arm,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [2+ADDR_W+DATA_W-1:0] rd_data,
    output logic [DEPTH_LOG2:0]        count,
    output logic                       capturing,
    output logic                       triggered,
    output logic                       overflow,
    output logic                       done
);

    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TYPE_READ  = 2'b00,
        TYPE_WRITE = 2'b01,
        TYPE_FETCH = 2'b10
    } cycle_type_t;

    state_t                 state_q, state_d;
    cycle_type_t            cyc_type;
    logic [DATA_W-1:0]      cyc_data;
    logic                   pass;
    logic                   qual, pop, push, full, overwrite, drop, trig_hit, grow;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    post_cnt;
    logic [ENTRY_W-1:0]     mem [DEPTH];

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cyc_type = TYPE_READ;
        cyc_data = data_i;
        if (sync) begin
            cyc_type = TYPE_FETCH;
        end else if (!rw) begin
            cyc_type = TYPE_WRITE;
            cyc_data = data_o;
        end

        pass = 1'b0;
        case (mode)
            2'd0:    pass = ph2;
            2'd1:    pass = ph2 & sync;
            2'd2:    pass = ph2 & ~sync & ~rw;
            default: pass = ph2 & (sync | ~rw);
        endcase
    end

    // Reset and arm both dominate: no sample is stored and no pop happens in those cycles.
    assign qual      = pass & ~rst & ~arm & ((state_q == ST_RUN) | (state_q == ST_POST));
    assign pop       = rd_en & ~rst & ~arm & (count != '0);
    assign full      = (count == FULL_COUNT);
    assign overwrite = qual & full & ~pop & trig_en;
    assign drop      = qual & full & ~pop & ~trig_en;
    assign push      = qual & ~drop;
    assign grow      = push & ~overwrite;
    assign trig_hit  = qual & trig_en & (state_q == ST_RUN) & (address == trig_addr);

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (trig_hit) state_d = (post_count == '0) ? ST_DONE : ST_POST;
                ST_POST: if (qual && post_cnt == CNT_ONE) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_valid <= pop;
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                // An overwrite discards the oldest entry, so the read side moves with it.
                if (pop || overwrite) rd_ptr <= rd_ptr + PTR_ONE;
                if (grow && !pop) begin
                    count <= count + CNT_ONE;
                end else if (!grow && pop) begin
                    count <= count - CNT_ONE;
                end
                if (overwrite || drop) overflow <= 1'b1;
                if (trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= post_count;
                end else if (qual && state_q == ST_POST) begin
                    post_cnt <= post_cnt - CNT_ONE;
                end
            end
        end
    end

    // NOTE: the trace memory has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cyc_type, address, cyc_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (pop) begin
            rd_data <= mem[rd_ptr];
        end
    end

    assign capturing = (state_q == ST_RUN) | (state_q == ST_POST);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_bus_trace_buffer.sv
// Directed bench for bus_trace_buffer: stimulus pushes expected pops into a scoreboard
// queue, a negedge monitor compares every rd_valid beat; flags are checked inline.
module tb_bus_trace_buffer;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DL = 2;
    localparam int EW = 2 + AW + DW;

    localparam logic [1:0] T_RD = 2'b00;
    localparam logic [1:0] T_WR = 2'b01;
    localparam logic [1:0] T_FE = 2'b10;

    logic          clk;
    logic          rst;
    logic          ph2, sync, rw;
    logic [AW-1:0] address;
    logic [DW-1:0] data_i, data_o;
    logic [1:0]    mode;
    logic          trig_en;
    logic [AW-1:0] trig_addr;
    logic [DL:0]   post_count;
    logic          arm, rd_en;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [DL:0]   count;
    logic          capturing, triggered, overflow, done;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    bus_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rst        (rst),
        .ph2        (ph2),
        .sync       (sync),
        .rw         (rw),
        .address    (address),
        .data_i     (data_i),
        .data_o     (data_o),
        .mode       (mode),
        .trig_en    (trig_en),
        .trig_addr  (trig_addr),
        .post_count (post_count),
        .arm        (arm),
        .rd_en      (rd_en),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count),
        .capturing  (capturing),
        .triggered  (triggered),
        .overflow   (overflow),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] ent(input logic [1:0] t, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d);
        return {t, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every read beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %h expected no read beat", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle; the unselected data bus carries the complement to expose a wrong mux.
    task automatic bus(input logic s, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic pop_too, input logic [EW-1:0] pexp);
        ph2     = 1'b1;
        sync    = s;
        rw      = r;
        address = a;
        data_i  = (s | r) ? d : ~d;
        data_o  = (s | r) ? ~d : d;
        rd_en   = pop_too;
        if (pop_too) exp_q.push_back(pexp);
        tick();
        ph2   = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus(1'b1, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rdc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus(1'b0, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic wrc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus(1'b0, 1'b0, a, d, 1'b0, '0);
    endtask

    task automatic pop(input logic [EW-1:0] e);
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    // Arm with a fetch on the bus in the same cycle; that sample must be discarded.
    task automatic do_arm();
        arm     = 1'b1;
        ph2     = 1'b1;
        sync    = 1'b1;
        rw      = 1'b1;
        address = 16'hFFFF;
        tick();
        arm = 1'b0;
        ph2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ph2 = 1'b0; sync = 1'b0; rw = 1'b1; address = '0;
        data_i = '0; data_o = '0; mode = 2'd0; trig_en = 1'b0; trig_addr = '0;
        post_count = '0; arm = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_capturing", 32'(capturing), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Idle: nothing is stored before arm
        fetch(16'h0010, 8'h01);
        check("idle_no_store", 32'(count), 32'd0);

        // Linear fill with drop on full
        do_arm();
        check("arm_count", 32'(count), 32'd0);
        check("arm_capturing", 32'(capturing), 32'd1);
        fetch(16'h0200, 8'hA9);
        rdc(16'h0201, 8'h55);
        wrc(16'h0300, 8'h12);
        rdc(16'h0302, 8'h34);
        check("lin_no_ovf_yet", 32'(overflow), 32'd0);
        rdc(16'h0303, 8'h56);
        rdc(16'h0304, 8'h78);
        check("lin_count", 32'(count), 32'd4);
        check("lin_overflow", 32'(overflow), 32'd1);
        check("lin_still_run", 32'(capturing), 32'd1);
        check("lin_no_trig", 32'(triggered), 32'd0);
        pop(ent(T_FE, 16'h0200, 8'hA9));
        pop(ent(T_RD, 16'h0201, 8'h55));
        pop(ent(T_WR, 16'h0300, 8'h12));
        pop(ent(T_RD, 16'h0302, 8'h34));
        check("lin_drained", 32'(count), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("empty_pop_count", 32'(count), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'(ent(T_RD, 16'h0302, 8'h34)));

        // Fetch-only filter
        mode = 2'd1;
        do_arm();
        fetch(16'h1000, 8'hE1);
        rdc(16'h1001, 8'h11);
        wrc(16'h1002, 8'h22);
        fetch(16'h1003, 8'hE2);
        rdc(16'h1004, 8'h33);
        wrc(16'h1005, 8'h44);
        rdc(16'h1006, 8'h55);
        fetch(16'h1007, 8'hE3);
        check("mode1_count", 32'(count), 32'd3);
        check("mode1_overflow", 32'(overflow), 32'd0);
        pop(ent(T_FE, 16'h1000, 8'hE1));
        pop(ent(T_FE, 16'h1003, 8'hE2));
        pop(ent(T_FE, 16'h1007, 8'hE3));

        // Circular pre-trigger capture with post_count=2
        mode = 2'd0; trig_en = 1'b1; trig_addr = 16'h0400; post_count = 3'd2;
        do_arm();
        for (int i = 0; i < 7; i++) fetch(16'h0100 + 16'(i), 8'(i) ^ 8'h5A);
        check("circ_count", 32'(count), 32'd4);
        check("circ_overflow", 32'(overflow), 32'd1);
        check("circ_not_trig", 32'(triggered), 32'd0);
        fetch(16'h0400, 8'hC0);
        check("trig_seen", 32'(triggered), 32'd1);
        check("trig_post_capturing", 32'(capturing), 32'd1);
        check("trig_not_done", 32'(done), 32'd0);
        fetch(16'h0401, 8'hC1);
        check("post1_not_done", 32'(done), 32'd0);
        fetch(16'h0402, 8'hC2);
        check("post_done", 32'(done), 32'd1);
        check("post_capturing_off", 32'(capturing), 32'd0);
        fetch(16'h0403, 8'hC3);
        check("done_count", 32'(count), 32'd4);
        pop(ent(T_FE, 16'h0106, 8'h06 ^ 8'h5A));
        pop(ent(T_FE, 16'h0400, 8'hC0));
        pop(ent(T_FE, 16'h0401, 8'hC1));
        pop(ent(T_FE, 16'h0402, 8'hC2));
        check("done_drained", 32'(count), 32'd0);

        // post_count=0: trigger on the first qualified cycle goes straight to DONE
        post_count = 3'd0;
        do_arm();
        fetch(16'h0400, 8'hD0);
        check("pc0_triggered", 32'(triggered), 32'd1);
        check("pc0_done", 32'(done), 32'd1);
        check("pc0_count", 32'(count), 32'd1);
        wrc(16'h0500, 8'hD1);
        check("pc0_no_more", 32'(count), 32'd1);
        pop(ent(T_FE, 16'h0400, 8'hD0));

        // Full buffer with simultaneous pop and qualified write
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 4; i++) wrc(16'h2000 + 16'(i), 8'h20 + 8'(i));
        bus(1'b0, 1'b0, 16'h2004, 8'h24, 1'b1, ent(T_WR, 16'h2000, 8'h20));
        check("pushpop_count", 32'(count), 32'd4);
        check("pushpop_no_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 5; i++) pop(ent(T_WR, 16'h2000 + 16'(i), 8'h20 + 8'(i)));

        // Re-arm during POST, then reset mid-capture
        trig_en = 1'b1; trig_addr = 16'h0400; post_count = 3'd5;
        do_arm();
        fetch(16'h0400, 8'hB0);
        fetch(16'h0401, 8'hB1);
        fetch(16'h0402, 8'hB2);
        check("post3_count", 32'(count), 32'd3);
        check("post3_in_post", 32'({capturing, done, triggered}), 32'b101);
        do_arm();
        check("rearm_count", 32'(count), 32'd0);
        check("rearm_triggered", 32'(triggered), 32'd0);
        check("rearm_overflow", 32'(overflow), 32'd0);
        check("rearm_run", 32'({capturing, done}), 32'b10);
        fetch(16'h0600, 8'hA0);
        wrc(16'h0601, 8'hA1);
        check("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1; rd_en = 1'b1; ph2 = 1'b1; sync = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0; ph2 = 1'b0;
        check("rst_outputs", 32'({rd_valid, count, capturing, triggered, overflow, done}), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_trace_buffer.md
# bus_trace_buffer

Synthesizable bus-cycle trace capture for the AK6502 CPU bus. It samples every bus cycle qualified by `ph2` and classifies it as opcode fetch, read or write. Qualified cycles pass through a mode filter and are stored in a parametrised circular trace memory. An optional address trigger with post-trigger count freezes the capture window. It replaces display-only bench tracing with a block that can sit beside the CPU in the SoC or a bench and be drained by a host-side reader.

## Interface
Parameters:
- ADDR_W, 16, CPU address bus width
- DATA_W, 8, CPU data bus width
- DEPTH_LOG2, 6, log2 of trace depth (DEPTH = 2**DEPTH_LOG2 entries)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- ph2  in  1  bus-cycle valid strobe; a cycle is sampled only when high
- sync  in  1  opcode-fetch cycle indicator
- rw  in  1  1 = read, 0 = write
- address  in  ADDR_W  bus address
- data_i  in  DATA_W  data toward CPU (captured on reads and fetches)
- data_o  in  DATA_W  data from CPU (captured on writes)
- mode  in  2  filter: 0 all cycles, 1 fetches only, 2 writes only, 3 fetches plus writes
- trig_en  in  1  1 = circular pre-trigger capture with address trigger; 0 = linear fill
- trig_addr  in  ADDR_W  trigger address
- post_count  in  DEPTH_LOG2+1  qualified cycles captured after the trigger cycle
- arm  in  1  single-cycle pulse; clears buffer and flags and starts capture
- rd_en  in  1  pop oldest entry
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  2+ADDR_W+DATA_W  {type[1:0], address, data}; type 00 read, 01 write, 10 fetch
- count  out  DEPTH_LOG2+1  entries held, 0..DEPTH
- capturing  out  1  state is RUN or POST
- triggered  out  1  sticky; trigger cycle seen
- overflow  out  1  sticky; qualified cycle dropped (linear) or entry overwritten (circular)
- done  out  1  state is DONE

## Operation
- States: IDLE, RUN, POST, DONE. Reset sets IDLE. Every output resets to 0 and the pointers are cleared.
- `arm` in any state clears pointers, count, `triggered`, `overflow` and the post counter, then enters RUN. Any sample in the `arm` cycle is discarded.
- Classification: `ph2 & sync` gives fetch with data_i; `ph2 & ~sync & rw` gives read with data_i; `ph2 & ~rw` gives write with data_o. The `sync` flag takes priority over `rw`.
- Qualified cycle: classified `ph2` cycle that passes the `mode` filter, with state RUN or POST. Only qualified cycles are stored. In IDLE and DONE nothing is stored.
- When `trig_en=0`, the buffer fills linearly. A qualified cycle arriving when count=DEPTH and no pop occurs in that cycle is dropped and sets `overflow`. The state stays RUN until the next `arm`. The trigger is ignored.
- When `trig_en=1`, the buffer is circular. A qualified cycle arriving when full with no pop in that cycle overwrites the oldest entry, advances the read pointer and sets `overflow`. The count stays at DEPTH.
- Trigger: in RUN with `trig_en=1`, a qualified cycle with `address==trig_addr` is stored. It sets `triggered`, loads the post counter with `post_count` and moves to POST. If `post_count=0`, the state goes directly to DONE.
- POST: each qualified cycle is stored and decrements the post counter. The cycle that brings the counter to 0 is stored, and the state then moves to DONE. Trigger matches in POST are ignored.
- Read: `rd_en` with count>0 pops the oldest entry. `rd_en` with count=0 is ignored. Reads are allowed in every state, including during capture.
- Simultaneous push and pop: both happen. The count is unchanged, and no overwrite or drop occurs when full.
- The trace memory uses single-write and single-read ports. It maps to inferred RAM with the read data registered.

## Timing
- Sample at cycle N gives the entry written, `count` updated, and `triggered` and the state change visible at N+1.
- `rd_en` at cycle N gives `rd_valid=1` and `rd_data` at N+1, and the `count` decrement visible at N+1. `rd_data` holds its value when `rd_valid=0`.
- `arm` at N puts the state in RUN and `count=0` at N+1. A qualified cycle at N+1 is stored.
- `rst` overrides `arm`, capture and reads in the same cycle.
- Throughput: one capture and one pop per cycle, sustained.

## Test plan
- DEPTH_LOG2=2, mode=0, trig_en=0, arm, then 6 cycles: fetch A9@0200, read 55@0201, write 12@0300, then 3 more reads. Expect count=4, `overflow=1`, and pops returning {10,0200,A9}, {00,0201,55}, {01,0300,12}, then the 4th read.
- mode=1, a mix of 3 fetches and 5 reads/writes. Expect count=3, with only type 10 entries popped in order.
- DEPTH_LOG2=2, trig_en=1, trig_addr=0400, post_count=2, fetches at 0100..0106 then 0400, 0401, 0402, 0403. Expect `done=1` after 0402 and `overflow=1`. Pops return 0106, 0400, 0401, 0402, and 0403 is not stored.
- post_count=0 with the trigger on the first qualified cycle. Expect `triggered=1`, `done=1`, count=1, and the state reaching DONE one cycle after the sample.
- Full buffer with `rd_en` and a qualified write in the same cycle. Expect count unchanged at DEPTH, no `overflow`, and the popped entry being the oldest.
- `arm` asserted in POST with count=3. Expect count=0, `triggered=0`, `overflow=0` and the state in RUN next cycle. `rst` mid-capture clears all outputs to 0 in the next cycle.
